// File: rtl/envelope_generator_if.sv
// Sample/control bundle for envelope_generator: note and tone inputs from the
// synth front end, enveloped sample and status outputs toward the mixer.
interface envelope_generator_if;
  logic               new_note;
  logic [15:0]        sustain_count;
  logic               sample_ready;
  logic signed [15:0] sample_in;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic [7:0]         gain;
  logic [2:0]         state;
  logic               active;

  modport master (
    output new_note, sustain_count, sample_ready, sample_in,
    input  sample_out, sample_valid, gain, state, active
  );

  modport slave (
    input  new_note, sustain_count, sample_ready, sample_in,
    output sample_out, sample_valid, gain, state, active
  );
endinterface

// File: rtl/envelope_generator.sv
// ADSR envelope generator: steps an 8-bit gain once per sample tick and
// scales the incoming tone sample by it, one cycle of latency.
module envelope_generator #(
  parameter int unsigned ATTACK_STEP   = 8,
  parameter int unsigned DECAY_STEP    = 1,
  parameter int unsigned SUSTAIN_LEVEL = 160,
  parameter int unsigned RELEASE_STEP  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  envelope_generator_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  // Steps are clamped to 255 so the 9/10-bit intermediates can never wrap.
  localparam logic [8:0]        ATT  = (ATTACK_STEP   > 255) ? 9'd255  : 9'(ATTACK_STEP);
  localparam logic [9:0]        DEC  = (DECAY_STEP    > 255) ? 10'd255 : 10'(DECAY_STEP);
  localparam logic [9:0]        REL  = (RELEASE_STEP  > 255) ? 10'd255 : 10'(RELEASE_STEP);
  localparam logic signed [9:0] SUS  = (SUSTAIN_LEVEL > 255) ? 10'sd255 : 10'(SUSTAIN_LEVEL);
  localparam logic [7:0]        SUS8 = (SUSTAIN_LEVEL > 255) ? 8'd255  : 8'(SUSTAIN_LEVEL);

  env_state_t         st;
  logic [7:0]         gain_r;
  logic [15:0]        sus_len;
  logic [15:0]        hold_cnt;
  logic signed [15:0] out_r;
  logic               valid_r;

  logic [8:0]         att_sum;
  logic signed [9:0]  dec_diff;
  logic signed [9:0]  rel_diff;
  logic signed [24:0] smp_ext;
  logic signed [24:0] gain_ext;
  logic signed [24:0] prod;

  assign att_sum  = {1'b0, gain_r} + ATT;
  assign dec_diff = $signed({2'b00, gain_r}) - $signed(DEC);
  assign rel_diff = $signed({2'b00, gain_r}) - $signed(REL);

  // Gain is zero-extended to a positive 9-bit signed factor before the multiply.
  assign smp_ext  = 25'(bus.sample_in);
  assign gain_ext = 25'({1'b0, gain_r});
  assign prod     = smp_ext * gain_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      gain_r   <= '0;
      sus_len  <= '0;
      hold_cnt <= '0;
      out_r    <= '0;
      valid_r  <= 1'b0;
    end else begin
      valid_r <= bus.sample_ready;
      if (bus.sample_ready)
        out_r <= 16'(prod >>> 8);

      if (bus.new_note) begin
        sus_len <= bus.sustain_count;
        st      <= ATTACK;
      end else if (bus.sample_ready) begin
        case (st)
          IDLE: gain_r <= '0;
          ATTACK: begin
            if (att_sum >= 9'd255) begin
              gain_r <= '1;
              st     <= DECAY;
            end else begin
              gain_r <= att_sum[7:0];
            end
          end
          DECAY: begin
            if (dec_diff <= SUS) begin
              gain_r   <= SUS8;
              hold_cnt <= sus_len;
              st       <= SUSTAIN;
            end else begin
              gain_r <= dec_diff[7:0];
            end
          end
          SUSTAIN: begin
            gain_r <= SUS8;
            if (hold_cnt == '0)
              st <= RELEASE;
            else
              hold_cnt <= hold_cnt - 16'd1;
          end
          RELEASE: begin
            if (rel_diff <= 10'sd0) begin
              gain_r <= '0;
              st     <= IDLE;
            end else begin
              gain_r <= rel_diff[7:0];
            end
          end
          default: begin
            gain_r <= '0;
            st     <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sample_out   = out_r;
  assign bus.sample_valid = valid_r;
  assign bus.gain         = gain_r;
  assign bus.state        = st;
  assign bus.active       = (st != IDLE);

endmodule

// File: tb/tb_envelope_generator.sv
// Directed bench for envelope_generator: expected samples go into a queue
// at issue time and a negedge monitor pops them on every sample_valid.
module tb_envelope_generator;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  envelope_generator_if bus();

  envelope_generator #(
    .ATTACK_STEP(8),
    .DECAY_STEP(1),
    .SUSTAIN_LEVEL(160),
    .RELEASE_STEP(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int eg    = 0;
  logic signed [15:0] expq[$];
  logic signed [15:0] mon_e;
  logic signed [15:0] last_exp;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [15:0] scaled(input int s, input int g);
    int p;
    p = s * g;
    return 16'(p >>> 8);
  endfunction

  // One sample tick starting and ending on a falling edge; exp_o overrides the model.
  task automatic tick(input int s, input bit nn = 1'b0, input int exp_o = 99999);
    logic signed [15:0] e;
    bus.sample_in    = 16'(s);
    bus.sample_ready = 1'b1;
    bus.new_note     = nn;
    if (reset) begin
      e = (exp_o == 99999) ? scaled(s, eg) : 16'(exp_o);
      expq.push_back(e);
      last_exp = e;
    end
    @(posedge clk); #1;
    bus.sample_ready = 1'b0;
    bus.new_note     = 1'b0;
    @(negedge clk);
  endtask

  task automatic note(input int cnt);
    bus.sustain_count = 16'(cnt);
    bus.new_note      = 1'b1;
    @(posedge clk); #1;
    bus.new_note = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.sample_valid === 1'b1) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_valid: got sample_valid=1 expected no pulse (sample_out=%0d)",
                 bus.sample_out);
      end else begin
        mon_e = expq.pop_front();
        check("sample_out", bus.sample_out, mon_e);
      end
    end
  end

  initial begin
    reset             = 1'b0;
    bus.new_note      = 1'b0;
    bus.sustain_count = '0;
    bus.sample_ready  = 1'b0;
    bus.sample_in     = '0;
    last_exp          = '0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_state",  bus.state, 0);
    check("rst_gain",   bus.gain, 0);
    check("rst_out",    bus.sample_out, 0);
    check("rst_valid",  bus.sample_valid, 0);
    check("rst_active", bus.active, 0);
    @(negedge clk);
    tick(1234);
    reset = 1'b1;
    @(negedge clk);
    check("rel_no_valid", bus.sample_valid, 0);
    check("rel_state", bus.state, 0);

    tick(32767);
    check("idle_state", bus.state, 0);
    check("idle_gain", bus.gain, 0);

    // Envelope 1: full ADSR, sustain_count=3
    note(3);
    check("note_state", bus.state, 1);
    check("note_gain", bus.gain, 0);
    for (int k = 1; k <= 32; k++) begin
      tick(k * 500 - 8000);
      eg = (8 * k > 255) ? 255 : 8 * k;
      check("attack_gain", bus.gain, eg);
      if (k == 31) check("attack_state31", bus.state, 1);
      if (k == 32) check("attack_state32", bus.state, 2);
    end
    for (int k = 1; k <= 95; k++) begin
      if (k == 1) tick(-1000, 1'b0, -997);
      else        tick(k * 300 - 14000);
      eg = 255 - k;
      check("decay_gain", bus.gain, eg);
      if (k == 94) check("decay_state94", bus.state, 2);
      if (k == 95) check("decay_state95", bus.state, 3);
    end
    for (int k = 1; k <= 4; k++) begin
      tick(20000 - k);
      eg = 160;
      check("sustain_gain", bus.gain, 160);
      check("sustain_state", bus.state, (k < 4) ? 3 : 4);
    end
    for (int k = 1; k <= 80; k++) begin
      if (k == 17) tick(1000, 1'b0, 500);
      else         tick(k * 37 - 3000);
      eg = 160 - 2 * k;
      check("release_gain", bus.gain, eg);
    end
    check("release_end_state", bus.state, 0);
    check("release_end_active", bus.active, 0);
    repeat (2) @(negedge clk);
    check("out_hold", bus.sample_out, last_exp);
    check("valid_low", bus.sample_valid, 0);

    // Envelope 2: sustain_count=0, retrigger in RELEASE at gain 100
    note(0);
    for (int k = 1; k <= 32; k++) begin
      tick(3000 - k * 41);
      eg = (8 * k > 255) ? 255 : 8 * k;
    end
    for (int k = 1; k <= 95; k++) begin
      tick(k * 211 - 9000);
      eg = 255 - k;
    end
    check("sc0_state", bus.state, 3);
    tick(7777);
    check("sc0_one_tick", bus.state, 4);
    for (int k = 1; k <= 30; k++) begin
      tick(12000 - k * 333);
      eg = 160 - 2 * k;
    end
    check("pre_retrig_gain", bus.gain, 100);
    bus.sustain_count = 16'd1000;
    tick(1500, 1'b1);
    check("retrig_gain", bus.gain, 100);
    check("retrig_state", bus.state, 1);
    tick(-2500);
    eg = 108;
    check("retrig_next_gain", bus.gain, 108);
    for (int k = 2; k <= 20; k++) begin
      tick(k * 100);
      eg = (100 + 8 * k > 255) ? 255 : 100 + 8 * k;
    end
    check("retrig_peak", bus.gain, 255);
    check("retrig_decay", bus.state, 2);
    for (int k = 1; k <= 95; k++) begin
      tick(-k * 50);
      eg = 255 - k;
    end
    for (int k = 1; k <= 3; k++) begin
      tick(20000);
      eg = 160;
    end
    check("mid_sustain", bus.state, 3);

    // Asynchronous reset between clock edges
    #3 reset = 1'b0;
    #1;
    check("arst_state", bus.state, 0);
    check("arst_gain", bus.gain, 0);
    check("arst_out", bus.sample_out, 0);
    check("arst_active", bus.active, 0);
    check("arst_valid", bus.sample_valid, 0);
    eg = 0;
    @(negedge clk);
    tick(5000);
    tick(-5000);
    reset = 1'b1;
    @(negedge clk);
    check("arst_rel_valid", bus.sample_valid, 0);
    check("arst_rel_state", bus.state, 0);
    tick(32767);
    check("post_rst_state", bus.state, 0);
    check("post_rst_gain", bus.gain, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drain", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
